// File: rtl/axis_packer_pkg.sv
// ----------------------------------------------------------------------------
// axis_packer_pkg
//   Shared types and default geometry for the AXI-Stream input packer and its
//   byte compactor (also used by the output-side unpacker).
//   - state_t           : packer FSM state (ACCUM collects bytes, EMIT presents
//                         one wide beat downstream)
//   - DEF_*_DATA_WIDTH  : default bus widths used as parameter defaults
//   - IN_BYTES/OUT_BYTES: byte lanes of the default configuration
//   - *_CNT_W           : widths able to hold a byte count 0..N inclusive
// ----------------------------------------------------------------------------
package axis_packer_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } state_t;

   localparam int DEF_IN_DATA_WIDTH  = 64;
   localparam int DEF_OUT_DATA_WIDTH = 512;

   localparam int IN_BYTES  = DEF_IN_DATA_WIDTH / 8;
   localparam int OUT_BYTES = DEF_OUT_DATA_WIDTH / 8;

   localparam int IN_CNT_W  = $clog2(IN_BYTES + 1);
   localparam int OUT_CNT_W = $clog2(OUT_BYTES + 1);

endpackage

// File: rtl/axis_byte_compactor.sv
// ----------------------------------------------------------------------------
// axis_byte_compactor
//   Purely combinational. Squeezes out the null bytes of one AXI-Stream beat:
//   the bytes whose TKEEP bit is set are moved, in their original order, to
//   the low end of packed_data. Bytes above the valid count are zero.
//   Ports:
//     tdata       in  IN_DATA_WIDTH      beat data, byte k = bits [8k+:8]
//     tkeep       in  IN_DATA_WIDTH/8    per-byte valid, any pattern
//     packed_data out IN_DATA_WIDTH      valid bytes, LSB-aligned
//     count       out clog2(IB+1)        number of valid bytes (popcount)
// ----------------------------------------------------------------------------
module axis_byte_compactor
   import axis_packer_pkg::*;
#(
   parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
   localparam int IB           = IN_DATA_WIDTH / 8,
   localparam int CW           = $clog2(IB + 1)
) (
   input  logic [IN_DATA_WIDTH-1:0] tdata,
   input  logic [IB-1:0]            tkeep,
   output logic [IN_DATA_WIDTH-1:0] packed_data,
   output logic [CW-1:0]            count
);

   always_comb begin
      int unsigned pos;
      // NOTE: every output of a combinational block gets a value before any
      // conditional code; otherwise untouched bits would hold their old value
      // and synthesis would infer a latch.
      packed_data = '0;
      pos         = 0;
      for (int k = 0; k < IB; k++) begin
         if (tkeep[k]) begin
            packed_data[pos*8 +: 8] = tdata[k*8 +: 8];
            pos++;
         end
      end
      count = CW'(pos);
   end

endmodule

// File: rtl/axis_input_packer.sv
// ----------------------------------------------------------------------------
// axis_input_packer
//   Packs a narrow AXI-Stream with sparse TKEEP into wide, dense, LSB-aligned
//   beats. Valid bytes are appended to an accumulator; a wide beat is emitted
//   when it fills or the packet ends. Bytes spilling past a full accumulator
//   wait in a carry buffer and seed the next wide beat.
//   Ports:
//     i_clk            in   clock, rising edge
//     i_reset          in   synchronous active-high reset, drops buffered data
//     i_input_TVALID   in   input beat valid
//     o_input_TREADY   out  high in ACCUM (never during reset)
//     i_input_TDATA    in   IN_DATA_WIDTH input data
//     i_input_TKEEP    in   IN_DATA_WIDTH/8 per-byte valid, may be sparse
//     i_input_TLAST    in   last beat of packet
//     o_output_TVALID  out  registered output valid
//     i_output_TREADY  in   downstream accepts
//     o_output_TDATA   out  OUT_DATA_WIDTH packed data, unused bytes zero
//     o_output_TKEEP   out  OUT_DATA_WIDTH/8 contiguous ones from bit 0
//     o_output_TLAST   out  last beat of packet
// ----------------------------------------------------------------------------
module axis_input_packer
   import axis_packer_pkg::*;
#(
   parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
   parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_input_TVALID,
   output logic                        o_input_TREADY,
   input  logic [IN_DATA_WIDTH-1:0]    i_input_TDATA,
   input  logic [IN_DATA_WIDTH/8-1:0]  i_input_TKEEP,
   input  logic                        i_input_TLAST,
   output logic                        o_output_TVALID,
   input  logic                        i_output_TREADY,
   output logic [OUT_DATA_WIDTH-1:0]   o_output_TDATA,
   output logic [OUT_DATA_WIDTH/8-1:0] o_output_TKEEP,
   output logic                        o_output_TLAST
);

   localparam int IB       = IN_DATA_WIDTH / 8;
   localparam int OB       = OUT_DATA_WIDTH / 8;
   localparam int IN_CW    = $clog2(IB + 1);
   localparam int CNT_W    = $clog2(OB + 1);
   localparam int EXT_W    = OUT_DATA_WIDTH + IN_DATA_WIDTH;
   localparam logic [CNT_W:0] OB_SUM = (CNT_W + 1)'(OB);

   // Architectural state
   state_t                     state_q, state_d;
   logic [OUT_DATA_WIDTH-1:0]  acc_data_q;
   logic [CNT_W-1:0]           acc_count_q;
   // Carry holds at most IB-1 bytes; it is kept a full input beat wide so the
   // top slice of the merged word drops straight in.
   logic [IN_DATA_WIDTH-1:0]   carry_data_q;
   logic [CNT_W-1:0]           carry_count_q;
   logic                       carry_last_q;
   logic                       emit_last_q;
   logic                       out_valid_q;
   logic [OB-1:0]              out_keep_q;
   logic                       out_last_q;

   // Datapath helpers
   logic [IN_DATA_WIDTH-1:0]   packed_data;
   logic [IN_CW-1:0]           n_bytes;
   logic [CNT_W:0]             sum;
   logic [EXT_W-1:0]           merged;
   logic [OB-1:0]              keep_mask;

   // FSM decode
   logic in_ready;
   logic accept;
   logic go_emit;
   logic go_last;
   logic overflow;
   logic present;
   logic out_fire;
   logic reemit;

   axis_byte_compactor #(
      .IN_DATA_WIDTH (IN_DATA_WIDTH)
   ) u_compactor (
      .tdata       (i_input_TDATA),
      .tkeep       (i_input_TKEEP),
      .packed_data (packed_data),
      .count       (n_bytes)
   );

   assign sum = {1'b0, acc_count_q} + (CNT_W + 1)'(n_bytes);

   // Accumulator with the compacted beat shifted in at byte acc_count. The
   // part above OUT_DATA_WIDTH is whatever spills into the carry buffer.
   // Both operands are zero above their valid bytes, so OR is a safe merge.
   assign merged = {{IN_DATA_WIDTH{1'b0}}, acc_data_q}
                 | ({{OUT_DATA_WIDTH{1'b0}}, packed_data} << {acc_count_q, 3'b000});

   always_comb begin
      keep_mask = '0;
      for (int i = 0; i < OB; i++) begin
         keep_mask[i] = (CNT_W'(i) < acc_count_q);
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of block order.
      if (i_reset) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      go_emit  = 1'b0;
      go_last  = 1'b0;
      overflow = 1'b0;
      present  = 1'b0;
      out_fire = 1'b0;
      reemit   = 1'b0;

      case (state_q)
         ST_ACCUM: begin
            in_ready = !i_reset;
            accept   = in_ready && i_input_TVALID;
            if (accept) begin
               if (sum > OB_SUM) begin
                  overflow = 1'b1;
                  go_emit  = 1'b1;
               end else if (sum == OB_SUM) begin
                  go_emit = 1'b1;
                  go_last = i_input_TLAST;
               end else if (i_input_TLAST && (sum != '0)) begin
                  go_emit = 1'b1;
                  go_last = 1'b1;
               end
               // An empty TLAST beat on an empty accumulator falls through:
               // nothing to emit, the beat is simply consumed.
            end
            if (go_emit) begin
               state_d = ST_EMIT;
            end
         end

         ST_EMIT: begin
            // First EMIT cycle raises the registered valid; afterwards the
            // beat is held until downstream takes it.
            present  = !out_valid_q;
            out_fire = out_valid_q && i_output_TREADY;
            if (out_fire) begin
               reemit  = (carry_count_q != '0) && carry_last_q;
               state_d = reemit ? ST_EMIT : ST_ACCUM;
            end
         end

         default: state_d = ST_ACCUM;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: the wide data registers are reset too: o_output_TDATA comes
         // straight from the accumulator and must read zero after reset, and
         // zeroed unused bytes are what make the OR-merge above valid.
         acc_data_q    <= '0;
         acc_count_q   <= '0;
         carry_data_q  <= '0;
         carry_count_q <= '0;
         carry_last_q  <= 1'b0;
         emit_last_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_keep_q    <= '0;
         out_last_q    <= 1'b0;
      end else begin
         if (accept) begin
            acc_data_q  <= merged[OUT_DATA_WIDTH-1:0];
            acc_count_q <= overflow ? CNT_W'(OB) : CNT_W'(sum);
            if (overflow) begin
               carry_data_q  <= merged[EXT_W-1 -: IN_DATA_WIDTH];
               carry_count_q <= CNT_W'(sum - OB_SUM);
               carry_last_q  <= i_input_TLAST;
            end
            if (go_emit) begin
               emit_last_q <= go_last;
            end
         end

         if (present) begin
            out_valid_q <= 1'b1;
            out_keep_q  <= keep_mask;
            out_last_q  <= emit_last_q;
         end

         if (out_fire) begin
            out_valid_q   <= 1'b0;
            out_keep_q    <= '0;
            out_last_q    <= 1'b0;
            acc_data_q    <= OUT_DATA_WIDTH'(carry_data_q);
            acc_count_q   <= carry_count_q;
            carry_data_q  <= '0;
            carry_count_q <= '0;
            carry_last_q  <= 1'b0;
            // A pending final carry is always the tail of its packet.
            emit_last_q   <= reemit;
         end
      end
   end

   assign o_input_TREADY  = in_ready;
   assign o_output_TVALID = out_valid_q;
   assign o_output_TDATA  = acc_data_q;
   assign o_output_TKEEP  = out_keep_q;
   assign o_output_TLAST  = out_last_q;

endmodule

// File: tb/tb_axis_input_packer.sv
// ----------------------------------------------------------------------------
// tb_axis_input_packer
//   Directed stimulus with hand-derived expected wide beats. Stimulus pushes
//   the expected beat into a queue; a monitor pops and compares on every
//   output handshake and checks that held beats stay stable.
//   Inputs change 1 time unit after the rising edge, outputs are sampled on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_axis_input_packer;
   import axis_packer_pkg::*;

   localparam int IW = DEF_IN_DATA_WIDTH;
   localparam int OW = DEF_OUT_DATA_WIDTH;
   localparam int IB = IN_BYTES;
   localparam int OB = OUT_BYTES;

   typedef struct {
      logic [OW-1:0] data;
      logic [OB-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk;
   logic          i_reset;
   logic          i_input_TVALID;
   logic          o_input_TREADY;
   logic [IW-1:0] i_input_TDATA;
   logic [IB-1:0] i_input_TKEEP;
   logic          i_input_TLAST;
   logic          o_output_TVALID;
   logic          i_output_TREADY;
   logic [OW-1:0] o_output_TDATA;
   logic [OB-1:0] o_output_TKEEP;
   logic          o_output_TLAST;

   beat_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   axis_input_packer #(
      .IN_DATA_WIDTH  (IW),
      .OUT_DATA_WIDTH (OW)
   ) dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .i_input_TVALID  (i_input_TVALID),
      .o_input_TREADY  (o_input_TREADY),
      .i_input_TDATA   (i_input_TDATA),
      .i_input_TKEEP   (i_input_TKEEP),
      .i_input_TLAST   (i_input_TLAST),
      .o_output_TVALID (o_output_TVALID),
      .i_output_TREADY (i_output_TREADY),
      .o_output_TDATA  (o_output_TDATA),
      .o_output_TKEEP  (o_output_TKEEP),
      .o_output_TLAST  (o_output_TLAST)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [OW-1:0] actual,
                        input logic [OW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic push_exp(input logic [OW-1:0] d, input logic [OB-1:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      exp_q.push_back(b);
   endtask

   // Presents one input beat and returns one time unit after the edge that
   // accepted it.
   task automatic send(input logic [IW-1:0] d, input logic [IB-1:0] k, input logic l);
      int budget;
      bit done;
      budget = 0;
      done   = 1'b0;
      i_input_TVALID = 1'b1;
      i_input_TDATA  = d;
      i_input_TKEEP  = k;
      i_input_TLAST  = l;
      while (!done) begin
         @(negedge clk);
         if (o_input_TREADY) done = 1'b1;
         @(posedge clk);
         #1;
         budget++;
         if (!done && budget > 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: input not accepted after %0d cycles", budget);
            done = 1'b1;
         end
      end
      i_input_TVALID = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || o_output_TVALID) && budget < 300) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check(name, OW'(exp_q.size()), '0);
   endtask

   // Monitor / scoreboard
   initial begin
      beat_t prev;
      beat_t e;
      bit    held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            held = 1'b0;
         end else if (o_output_TVALID) begin
            if (held) begin
               check("hold_data", o_output_TDATA, prev.data);
               check("hold_keep", OW'(o_output_TKEEP), OW'(prev.keep));
               check("hold_last", OW'(o_output_TLAST), OW'(prev.last));
               check("hold_in_ready", OW'(o_input_TREADY), '0);
            end
            if (i_output_TREADY) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat: got keep %h last %0b with nothing expected",
                           o_output_TKEEP, o_output_TLAST);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", o_output_TDATA, e.data);
                  check("out_keep", OW'(o_output_TKEEP), OW'(e.keep));
                  check("out_last", OW'(o_output_TLAST), OW'(e.last));
               end
               held = 1'b0;
            end else begin
               held      = 1'b1;
               prev.data = o_output_TDATA;
               prev.keep = o_output_TKEEP;
               prev.last = o_output_TLAST;
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [OW-1:0] exp1;
      logic [OW-1:0] exp2;
      logic [IW-1:0] d;
      int            seen;

      i_reset         = 1'b1;
      i_input_TVALID  = 1'b0;
      i_input_TDATA   = '0;
      i_input_TKEEP   = '0;
      i_input_TLAST   = 1'b0;
      i_output_TREADY = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", OW'(o_input_TREADY), '0);
      check("rst_valid", OW'(o_output_TVALID), '0);
      check("rst_data", o_output_TDATA, '0);
      check("rst_keep", OW'(o_output_TKEEP), '0);
      check("rst_last", OW'(o_output_TLAST), '0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", OW'(o_input_TREADY), OW'(1));
      @(posedge clk);
      #1;

      // Single full beat
      push_exp(OW'(64'h0807060504030201), OB'(8'hFF), 1'b1);
      send(64'h0807060504030201, 8'hFF, 1'b1);
      wait_drain("drain_single");

      // Sparse TKEEP 0xA5 -> bytes 0,2,5,7
      push_exp(OW'(32'h88663311), OB'(4'hF), 1'b1);
      send(64'h8877665544332211, 8'hA5, 1'b1);
      wait_drain("drain_sparse");

      // Nine full beats: exact fill then a one-beat tail
      exp1 = '0;
      exp2 = '0;
      for (int j = 0; j < OB; j++) exp1[j*8 +: 8] = 8'(j + 1);
      for (int j = 0; j < 8; j++)  exp2[j*8 +: 8] = 8'(65 + j);
      push_exp(exp1, '1, 1'b0);
      push_exp(exp2, OB'(8'hFF), 1'b1);
      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < IB; k++) d[k*8 +: 8] = 8'(8*i + k + 1);
         send(d, 8'hFF, (i == 8));
      end
      wait_drain("drain_nine");

      // Overflow: 4 + 64 bytes, tail of 4 bytes comes from the carry
      exp1 = '0;
      exp2 = '0;
      for (int j = 0; j < 4; j++)  exp1[j*8 +: 8] = 8'(8'hA0 + j);
      for (int j = 4; j < OB; j++) exp1[j*8 +: 8] = 8'(8'h10 + j - 4);
      for (int j = 0; j < 4; j++)  exp2[j*8 +: 8] = 8'(8'h4C + j);
      push_exp(exp1, '1, 1'b0);
      push_exp(exp2, OB'(4'hF), 1'b1);
      send(64'hA7A6A5A4A3A2A1A0, 8'h0F, 1'b0);
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < IB; k++) d[k*8 +: 8] = 8'(8'h10 + 8*i + k);
         send(d, 8'hFF, (i == 7));
      end
      wait_drain("drain_overflow");

      // Backpressure: hold the beat for 5 cycles
      i_output_TREADY = 1'b0;
      push_exp(OW'(32'hD0C0B0A0), OB'(4'hF), 1'b1);
      send(64'hF0E0D0C0B0A09080, 8'h3C, 1'b1);
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk);
         if (o_output_TVALID) seen = 1;
         @(posedge clk);
         #1;
      end
      check("bp_valid_seen", OW'(seen), OW'(1));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid_held", OW'(o_output_TVALID), OW'(1));
         check("bp_in_ready_low", OW'(o_input_TREADY), '0);
         @(posedge clk);
         #1;
      end
      i_output_TREADY = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_dropped", OW'(o_output_TVALID), '0);
      check("bp_popped", OW'(exp_q.size()), '0);
      wait_drain("drain_bp");

      // Reset mid-packet discards buffered bytes
      for (int i = 0; i < 3; i++) send(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
      i_reset = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", OW'(o_input_TREADY), '0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      push_exp(OW'(16'h2211), OB'(2'h3), 1'b1);
      send(64'h8877665544332211, 8'h03, 1'b1);
      wait_drain("drain_after_reset");

      // Empty TLAST beat on empty accumulator: consumed, no output
      send(64'h0123456789ABCDEF, 8'h00, 1'b1);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_output_TVALID) seen++;
         @(posedge clk);
         #1;
      end
      check("empty_no_output", OW'(seen), '0);
      check("empty_in_ready", OW'(o_input_TREADY), OW'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_input_packer.md
Name: axis_input_packer

Overview:
- Upstream stage that feeds the packet-compute core.
- Accepts a narrow AXI-Stream from the UDP/network side, which may carry sparse TKEEP.
- Removes the null bytes and packs the valid bytes contiguously from byte 0 into wide output beats with a contiguous low-aligned TKEEP, so downstream sees dense, LSB-aligned words.
- Splits input bytes across output beats when a wide word fills, and preserves packet boundaries via TLAST.

Parameters:
- IN_DATA_WIDTH, 64, input bus width in bits; multiple of 8.
- OUT_DATA_WIDTH, 512, output bus width in bits; integer multiple of IN_DATA_WIDTH.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_input_TVALID  in  1  input beat valid.
- o_input_TREADY  out  1  packer can accept a beat.
- i_input_TDATA  in  IN_DATA_WIDTH  input data; byte k = bits [8k+:8].
- i_input_TKEEP  in  IN_DATA_WIDTH/8  per-byte valid; any pattern allowed.
- i_input_TLAST  in  1  last beat of packet.
- o_output_TVALID  out  1  output beat valid (registered).
- i_output_TREADY  in  1  downstream accepts.
- o_output_TDATA  out  OUT_DATA_WIDTH  packed data, byte 0 = first valid byte.
- o_output_TKEEP  out  OUT_DATA_WIDTH/8  contiguous ones from bit 0.
- o_output_TLAST  out  1  last beat of packet.

Behaviour:
- Notation: IB = IN_DATA_WIDTH/8, OB = OUT_DATA_WIDTH/8.
- Registers: accumulator acc_data (OB bytes), acc_count (0..OB); carry buffer carry_data (IB-1 bytes), carry_count, carry_last.
- Reset (i_reset=1 at clock edge): state ACCUM. All counts 0. o_input_TREADY=0 for that cycle. o_output_TVALID=0, o_output_TDATA=0, o_output_TKEEP=0, o_output_TLAST=0. Reset mid-packet discards all buffered bytes.
- Compaction: n = popcount(TKEEP). The valid bytes keep their relative order and are appended starting at acc_data byte acc_count.
- ACCUM:
  - o_input_TREADY=1. A beat is accepted when TVALID&&TREADY.
  - acc_count+n < OB, TLAST=0: append, stay in ACCUM.
  - acc_count+n == OB: append, go to EMIT with last=TLAST.
  - acc_count+n < OB, TLAST=1, acc_count+n > 0: append, go to EMIT with last=1.
  - acc_count+n == 0 with TLAST=1: drop the beat, no output, stay in ACCUM.
  - acc_count+n > OB: fill acc to OB. Put the remaining acc_count+n-OB bytes in carry, with carry_last=TLAST. Go to EMIT with last=0.
- EMIT:
  - o_input_TREADY=0.
  - On entry, o_output_TVALID=1, TDATA=acc_data (unused bytes 0), TKEEP=(1<<acc_count)-1, TLAST=last.
  - TVALID, TDATA, TKEEP and TLAST are held stable until i_output_TREADY=1.
  - On handshake, TVALID drops. acc loads from carry (acc_count=carry_count) and carry clears.
  - If carry_count>0 and carry_last=1, re-enter EMIT next cycle with last=1. Otherwise return to ACCUM.
- Latency: the completing beat is accepted at edge N; o_output_TVALID=1 after edge N+1 (one registered stage).
- Throughput: one input beat per cycle in ACCUM. At least one bubble per output beat, since there is no simultaneous accept and emit.
- TVALID never drops without a handshake. TKEEP is never sparse. TKEEP=0 never appears with TVALID=1.
- TREADY low does not change any state in EMIT except holding.

Decomposition:
- Shared package axis_packer_pkg:
  - state enum ACCUM/EMIT, 1-bit.
  - localparams IN_BYTES, OUT_BYTES and count widths clog2(OUT_BYTES+1).
- Sub-module axis_byte_compactor:
  - Combinational, parameter IN_DATA_WIDTH.
  - Inputs tdata and tkeep; outputs packed_data (LSB-aligned) and count n.
  - Reused later by the output-side unpacker.

Test Plan:
- Single beat TKEEP=0xFF, TDATA=0x0807060504030201, TLAST=1 -> one output: TKEEP=0x..00FF, low 64 bits=0x0807060504030201, upper bits 0, TLAST=1.
- Sparse TKEEP=0xA5, TDATA=0x8877665544332211, TLAST=1 -> output TKEEP=0xF, low 32 bits=0x88663311, TLAST=1.
- Nine full beats, TLAST on the ninth -> first output after beat 8 with TKEEP all-ones, TLAST=0; second output with TKEEP=0xFF, TLAST=1. Byte order is preserved across both.
- Overflow: TKEEP=0x0F beat, then eight 0xFF beats, the last with TLAST=1 (68 bytes) -> output 1: 64 bytes, TLAST=0; output 2: TKEEP=0xF, TLAST=1, containing the last 4 bytes.
- Backpressure: hold i_output_TREADY=0 for 5 cycles during EMIT -> TVALID/TDATA/TKEEP/TLAST stable, o_input_TREADY=0; the beat completes on the first TREADY=1 cycle.
- Reset after 3 beats of a packet, then a fresh 1-beat packet; plus a TKEEP=0/TLAST=1 beat on an empty accumulator -> only the fresh packet is output, and the empty beat produces no output.
